// File: rtl/joystick_conditioner.sv
// Left/right joystick conditioning: 2-FF sync, counter debounce, press strobe, fixed beep window.
// Optional auto-repeat while held is enabled by defining JOYSTICK_AUTOREPEAT_EN.
module joystick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BEEP_CYCLES     = 5_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic left_raw,
  input  logic right_raw,
  output logic left_level,
  output logic right_level,
  output logic left_pulse,
  output logic right_pulse,
  output logic joystick_left,
  output logic joystick_right
);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Configurations outside this range have no defined behaviour.
  if (DEBOUNCE_CYCLES < 2 || BEEP_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_unsupported_config
  end

  // Index 0 is the left channel, index 1 the right channel; state_q is the FSM debug view.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [CNT_W-1:0] beep_cnt_q [2];
  logic [CNT_W-1:0] beep_cnt_d [2];
  logic [1:0]       level_q, level_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [1:0]       joy_q, joy_d;
`ifdef JOYSTICK_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_cnt_q [2];
  logic [CNT_W-1:0] rep_cnt_d [2];
  logic [1:0]       rep_armed_q, rep_armed_d;
`endif

  always_comb begin
    sync1_d = {right_raw, left_raw};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      pulse_d[i] = 1'b0;
`ifdef JOYSTICK_AUTOREPEAT_EN
      rep_cnt_d[i]   = '0;
      rep_armed_d[i] = 1'b0;
`endif
      case (state_q[i])
        IDLE: begin
          level_d[i] = 1'b0;
          if (sync2_q[i]) begin
            state_d[i] = ARMING;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARMING: begin
          level_d[i] = 1'b0;
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          level_d[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = RELEASING;
            cnt_d[i]   = CNT_ONE;
          end
`ifdef JOYSTICK_AUTOREPEAT_EN
          // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          else if (rep_cnt_q[i] == (rep_armed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
            pulse_d[i]     = 1'b1;
            rep_armed_d[i] = 1'b1;
          end else begin
            rep_cnt_d[i]   = rep_cnt_q[i] + 1'b1;
            rep_armed_d[i] = rep_armed_q[i];
          end
`endif
        end
        RELEASING: begin
          level_d[i] = 1'b1;
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase

      // Window loads the cycle after the strobe, so it starts one cycle later.
      if (pulse_q[i]) begin
        beep_cnt_d[i] = BEEP_LOAD;
      end else if (beep_cnt_q[i] != '0) begin
        beep_cnt_d[i] = beep_cnt_q[i] - 1'b1;
      end else begin
        beep_cnt_d[i] = '0;
      end
      joy_d[i] = (beep_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      joy_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= IDLE;
        cnt_q[i]      <= '0;
        beep_cnt_q[i] <= '0;
`ifdef JOYSTICK_AUTOREPEAT_EN
        rep_cnt_q[i]  <= '0;
`endif
      end
`ifdef JOYSTICK_AUTOREPEAT_EN
      rep_armed_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      joy_q   <= joy_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        beep_cnt_q[i] <= beep_cnt_d[i];
`ifdef JOYSTICK_AUTOREPEAT_EN
        rep_cnt_q[i]  <= rep_cnt_d[i];
`endif
      end
`ifdef JOYSTICK_AUTOREPEAT_EN
      rep_armed_q <= rep_armed_d;
`endif
    end
  end

  assign left_level     = level_q[0];
  assign right_level    = level_q[1];
  assign left_pulse     = pulse_q[0];
  assign right_pulse    = pulse_q[1];
  assign joystick_left  = joy_q[0];
  assign joystick_right = joy_q[1];

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner (DEBOUNCE=8, BEEP=20, REPEAT 40/16).
// Times are cycle numbers t counted from the start of each scenario, sampled 1 ns after each edge.
module tb_joystick_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic left_raw, right_raw;
  logic left_level, right_level, left_pulse, right_pulse;
  logic joystick_left, joystick_right;

  joystick_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .BEEP_CYCLES(20),
    .REPEAT_DELAY(40),
    .REPEAT_PERIOD(16),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .left_raw(left_raw),
    .right_raw(right_raw),
    .left_level(left_level),
    .right_level(right_level),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .joystick_left(joystick_left),
    .joystick_right(joystick_right)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t;
  logic [15:0] exp_q[$];
  logic [15:0] lp_log[$];
  logic [15:0] rp_log[$];
  int jl_n, jl_first, jl_last, jr_n, jr_first, jr_last;
  int lh_n, lf_n, lf_t;
  logic lvl_prev;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    t = 0;
    lp_log.delete();
    rp_log.delete();
    jl_n = 0; jl_first = 0; jl_last = 0;
    jr_n = 0; jr_first = 0; jr_last = 0;
    lh_n = 0; lf_n = 0; lf_t = 0;
    lvl_prev = left_level;
  endtask

  task automatic step(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      t++;
      if (left_pulse)  lp_log.push_back(16'(t));
      if (right_pulse) rp_log.push_back(16'(t));
      if (joystick_left) begin
        jl_n++;
        if (jl_first == 0) jl_first = t;
        jl_last = t;
      end
      if (joystick_right) begin
        jr_n++;
        if (jr_first == 0) jr_first = t;
        jr_last = t;
      end
      if (left_level) lh_n++;
      if (lvl_prev && !left_level) begin
        lf_n++;
        lf_t = t;
      end
      lvl_prev = left_level;
    end
  endtask

  task automatic score_pulses(string tag, bit right_ch);
    logic [15:0] got_q[$];
    if (right_ch) got_q = rp_log;
    else          got_q = lp_log;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_at%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic score_window(string tag, bit right_ch, int n, int first, int last);
    check_eq({tag, "_len"},   right_ch ? jr_n : jl_n,         n);
    check_eq({tag, "_first"}, right_ch ? jr_first : jl_first, first);
    check_eq({tag, "_last"},  right_ch ? jr_last : jl_last,   last);
  endtask

  task automatic check_all_low(string tag);
    check_eq(tag, {left_level, right_level, left_pulse, right_pulse,
                   joystick_left, joystick_right}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    left_raw = 1'b0;
    right_raw = 1'b0;

    // Reset with the contact already held, then the full debounce on release.
    left_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_low("reset_outs");
    clear_logs();
    rst_n = 1'b1;
    step(40);
    exp_q.push_back(16'd10);
    score_pulses("rst_lp", 1'b0);
    score_window("rst_jl", 1'b0, 20, 11, 30);
    check_eq("rst_level_held", left_level, 1);
    check_eq("rst_rp_none", rp_log.size(), 0);
    clear_logs();
    left_raw = 1'b0;
    step(20);
    check_eq("rel_fall_t", lf_t, 10);
    check_eq("rel_no_pulse", lp_log.size(), 0);

    // Short glitch is rejected.
    clear_logs();
    left_raw = 1'b1;
    step(5);
    left_raw = 1'b0;
    step(20);
    check_eq("glitch_pulses", lp_log.size(), 0);
    check_eq("glitch_level", lh_n, 0);
    check_eq("glitch_jl", jl_n, 0);

    // One cycle short of the debounce: still rejected.
    clear_logs();
    left_raw = 1'b1;
    step(7);
    left_raw = 1'b0;
    step(20);
    check_eq("short7_pulses", lp_log.size(), 0);

    // Exactly long enough: accepted, then released straight away.
    clear_logs();
    left_raw = 1'b1;
    step(8);
    left_raw = 1'b0;
    step(40);
    exp_q.push_back(16'd10);
    score_pulses("min8_lp", 1'b0);
    check_eq("min8_fall_t", lf_t, 18);
    score_window("min8_jl", 1'b0, 20, 11, 30);

    // Bounce on release: one pulse, level falls 10 cycles after the final drop.
    clear_logs();
    left_raw = 1'b1;
    step(30);
    left_raw = 1'b0;
    step(3);
    left_raw = 1'b1;
    step(10);
    left_raw = 1'b0;
    step(30);
    exp_q.push_back(16'd10);
    score_pulses("bounce_lp", 1'b0);
    check_eq("bounce_falls", lf_n, 1);
    check_eq("bounce_fall_t", lf_t, 53);
    score_window("bounce_jl", 1'b0, 20, 11, 30);

    // Quickest possible re-press: second pulse at t=26 while the window runs.
    clear_logs();
    left_raw = 1'b1;
    step(8);
    left_raw = 1'b0;
    step(8);
    left_raw = 1'b1;
    step(10);
    left_raw = 1'b0;
    step(40);
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd26);
    score_pulses("retrig_lp", 1'b0);
    score_window("retrig_jl", 1'b0, 36, 11, 46);

    // Staggered presses: channels stay independent.
    clear_logs();
    left_raw = 1'b1;
    step(3);
    right_raw = 1'b1;
    step(20);
    left_raw = 1'b0;
    right_raw = 1'b0;
    step(40);
    exp_q.push_back(16'd10);
    score_pulses("stag_lp", 1'b0);
    exp_q.push_back(16'd13);
    score_pulses("stag_rp", 1'b1);
    score_window("stag_jl", 1'b0, 20, 11, 30);
    score_window("stag_jr", 1'b1, 20, 14, 33);

    // Simultaneous presses on both channels.
    clear_logs();
    left_raw = 1'b1;
    right_raw = 1'b1;
    step(12);
    left_raw = 1'b0;
    right_raw = 1'b0;
    step(40);
    exp_q.push_back(16'd10);
    score_pulses("both_lp", 1'b0);
    exp_q.push_back(16'd10);
    score_pulses("both_rp", 1'b1);
    score_window("both_jl", 1'b0, 20, 11, 30);
    score_window("both_jr", 1'b1, 20, 11, 30);

    // Long hold: auto-repeat pulses only when the feature is built in.
    clear_logs();
    left_raw = 1'b1;
    step(100);
    left_raw = 1'b0;
    step(30);
    exp_q.push_back(16'd10);
`ifdef JOYSTICK_AUTOREPEAT_EN
    exp_q.push_back(16'd50);
    exp_q.push_back(16'd66);
    exp_q.push_back(16'd82);
    exp_q.push_back(16'd98);
    score_pulses("hold_lp", 1'b0);
    score_window("hold_jl", 1'b0, 88, 11, 118);
`else
    score_pulses("hold_lp", 1'b0);
    score_window("hold_jl", 1'b0, 20, 11, 30);
`endif
    check_eq("hold_fall_t", lf_t, 110);

    // Reset mid-beep clears outputs at once; a held contact must re-debounce.
    clear_logs();
    left_raw = 1'b1;
    step(15);
    check_eq("mid_level_pre", left_level, 1);
    rst_n = 1'b0;
    #1;
    check_all_low("mid_reset_outs");
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    step(40);
    exp_q.push_back(16'd10);
    score_pulses("mid_lp", 1'b0);
    score_window("mid_jl", 1'b0, 20, 11, 30);
    left_raw = 1'b0;
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
